dis_idm_trace: RTL and testbench

Parametrised trace monitor for the instruction/data memory (IDM) port.
- Snoops every IDM access (read, write, or both in one cycle).
- Keeps running access counters.
- Records accesses into a circular trace buffer, with an address trigger and a post-trigger window.
- Sits beside the IDM at top level, purely observational; a testbench or debug logic reads the buffer back through a one-cycle readout port.

---
 rtl/dis_idm_trace.sv | 139 +++++++++++++
 tb/tb_dis_idm_trace.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dis_idm_trace.sv
// dis_idm_trace: IDM port snooper with access counters and a triggered circular trace buffer.
// Define DIS_IDM_TRACE_DISPLAY_EN to print every access and state change in simulation.
module dis_idm_trace #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CW        = 16,
    localparam int PW       = $clog2(DEPTH),
    localparam int EW       = 2 + AW + DW
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic [AW-1:0] idm_in_rwa,
    input  logic [DW-1:0] idm_in_wd,
    input  logic          idm_in_we,
    input  logic          idm_in_re,
    input  logic [DW-1:0] idm_out_rd,
    input  logic          arm,
    input  logic          trig_en,
    input  logic [AW-1:0] trig_addr,
    input  logic          tr_req,
    input  logic [PW-1:0] tr_idx,
    output logic          tr_valid,
    output logic [EW-1:0] tr_rdata,
    output logic [PW:0]   tr_count,
    output logic [1:0]    state_o,
    output logic [CW-1:0] rd_cnt,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] conf_cnt
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, FROZEN = 2'b11} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] post_cnt, post_nxt;
    logic [EW-1:0] mem [DEPTH];

    logic          access, capture, count_en, hit;
    logic [EW-1:0] entry;
    logic [PW-1:0] slot;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // arm takes priority over any access in the same cycle
    assign access   = idm_in_we | idm_in_re;
    assign capture  = access & ~arm & (state == ARMED || state == POST);
    assign count_en = access & ~arm & (state != IDLE);
    assign hit      = trig_en & (idm_in_rwa == trig_addr);
    assign entry    = {idm_in_we, idm_in_re, idm_in_rwa, idm_in_we ? idm_in_wd : idm_out_rd};
    assign slot     = wr_ptr - tr_count[PW-1:0] + tr_idx;
    assign state_o  = state;

    always_comb begin
        state_nxt = state;
        post_nxt  = post_cnt;
        if (arm) begin
            state_nxt = ARMED;
            post_nxt  = '0;
        end else if (capture) begin
            if (state == ARMED && hit) begin
                state_nxt = (POST_TRIG == 0) ? FROZEN : POST;
                post_nxt  = PW'(POST_TRIG);
            end else if (state == POST) begin
                post_nxt  = post_cnt - 1'b1;
                state_nxt = (post_cnt == PW'(1)) ? FROZEN : POST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= IDLE;
            post_cnt <= '0;
        end else begin
            state    <= state_nxt;
            post_cnt <= post_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr   <= '0;
            tr_count <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            tr_count <= '0;
        end else if (capture) begin
            wr_ptr   <= wr_ptr + 1'b1;
            tr_count <= (tr_count == (PW+1)'(DEPTH)) ? tr_count : tr_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            conf_cnt <= '0;
        end else if (arm) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            conf_cnt <= '0;
        end else if (count_en) begin
            if (idm_in_re & ~idm_in_we) rd_cnt <= sat_inc(rd_cnt);
            if (idm_in_we & ~idm_in_re) wr_cnt <= sat_inc(wr_cnt);
            if (idm_in_we & idm_in_re) conf_cnt <= sat_inc(conf_cnt);
        end
    end

    // storage is never reset; tr_count gates visibility of stale slots
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tr_valid <= 1'b0;
            tr_rdata <= '0;
        end else begin
            tr_valid <= tr_req;
            if (tr_req)
                tr_rdata <= (arm || {1'b0, tr_idx} >= tr_count) ? '0 : mem[slot];
            else
                tr_rdata <= '0;
        end
    end

`ifdef DIS_IDM_TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (rst_l && access)
            $display("%0t dis_idm_trace: state=%s kind=%b addr=%h data=%h",
                     $time, state.name(), entry[EW-1:EW-2], idm_in_rwa, entry[DW-1:0]);
        if (rst_l && state_nxt != state)
            $display("%0t dis_idm_trace: %s -> %s", $time, state.name(), state_nxt.name());
    end
`endif
endmodule

// File: tb/tb_dis_idm_trace.sv
// tb_dis_idm_trace: directed and randomized checks of dis_idm_trace against a queue-based trace model.
module tb_dis_idm_trace;
    localparam int AW = 10, DW = 32, DEPTH = 16, POST_TRIG = 4, CW = 16;
    localparam int PW = $clog2(DEPTH), EW = 2 + AW + DW;

    logic          clk = 0, rst_l = 0;
    logic [AW-1:0] idm_in_rwa = 0, trig_addr = 0;
    logic [DW-1:0] idm_in_wd = 0, idm_out_rd = 0;
    logic          idm_in_we = 0, idm_in_re = 0, arm = 0, trig_en = 0, tr_req = 0;
    logic [PW-1:0] tr_idx = 0;
    logic          tr_valid;
    logic [EW-1:0] tr_rdata;
    logic [PW:0]   tr_count;
    logic [1:0]    state_o;
    logic [CW-1:0] rd_cnt, wr_cnt, conf_cnt;

    dis_idm_trace #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CW(CW)) dut (
        .clk(clk), .rst_l(rst_l), .idm_in_rwa(idm_in_rwa), .idm_in_wd(idm_in_wd),
        .idm_in_we(idm_in_we), .idm_in_re(idm_in_re), .idm_out_rd(idm_out_rd),
        .arm(arm), .trig_en(trig_en), .trig_addr(trig_addr), .tr_req(tr_req), .tr_idx(tr_idx),
        .tr_valid(tr_valid), .tr_rdata(tr_rdata), .tr_count(tr_count), .state_o(state_o),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .conf_cnt(conf_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;

    // reference model: the trace is simply the last DEPTH captured entries, oldest first
    logic [EW-1:0] q[$];
    int m_state = 0, post_left = 0, m_rd = 0, m_wr = 0, m_cf = 0;
    localparam int CMAX = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0; post_left = 0; m_rd = 0; m_wr = 0; m_cf = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".state"}, 64'(state_o), 64'(m_state));
        chk({tag, ".count"}, 64'(tr_count), 64'(q.size()));
        chk({tag, ".rd_cnt"}, 64'(rd_cnt), 64'(m_rd));
        chk({tag, ".wr_cnt"}, 64'(wr_cnt), 64'(m_wr));
        chk({tag, ".conf_cnt"}, 64'(conf_cnt), 64'(m_cf));
    endtask

    // one clock: drive inputs, predict, clock, check every output
    task automatic cyc(input string tag, input bit a, input bit we, input bit re,
                       input int addr, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                       input bit req, input int idx);
        logic [EW-1:0] exp_rd;
        arm = a; idm_in_we = we; idm_in_re = re; idm_in_rwa = AW'(addr);
        idm_in_wd = wd; idm_out_rd = rd; tr_req = req; tr_idx = PW'(idx);
        exp_rd = (a || idx >= q.size()) ? '0 : q[idx];
        if (a) begin
            q.delete(); m_state = 1; post_left = 0; m_rd = 0; m_wr = 0; m_cf = 0;
        end else if (we || re) begin
            if (m_state != 0) begin
                if (we && !re && m_wr < CMAX) m_wr++;
                if (re && !we && m_rd < CMAX) m_rd++;
                if (we && re && m_cf < CMAX) m_cf++;
            end
            if (m_state == 1 || m_state == 2) begin
                q.push_back({we, re, AW'(addr), we ? wd : rd});
                if (q.size() > DEPTH) void'(q.pop_front());
                if (m_state == 1 && trig_en && AW'(addr) == trig_addr) begin
                    post_left = POST_TRIG;
                    m_state = (POST_TRIG == 0) ? 3 : 2;
                end else if (m_state == 2) begin
                    post_left--;
                    if (post_left == 0) m_state = 3;
                end
            end
        end
        @(posedge clk); #1;
        arm = 0; idm_in_we = 0; idm_in_re = 0; tr_req = 0;
        check_regs(tag);
        chk({tag, ".valid"}, 64'(tr_valid), 64'(req));
        if (req) chk({tag, ".rdata"}, 64'(tr_rdata), 64'(exp_rd));
    endtask

    task automatic rd_entry(input string tag, input int idx);
        cyc(tag, 0, 0, 0, 0, 0, 0, 1, idx);
    endtask

    initial begin
        // reset state
        #3;
        chk("rst.state", 64'(state_o), 0);
        chk("rst.count", 64'(tr_count), 0);
        chk("rst.rdata", 64'(tr_rdata), 0);
        @(negedge clk); rst_l = 1;
        @(posedge clk); #1;
        cyc("idle_wr", 0, 1, 0, 5, 32'h1, 0, 0, 0);

        // basic capture: two writes and a read
        cyc("arm1", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("w10", 0, 1, 0, 'h010, 32'hAAAA0001, 0, 0, 0);
        cyc("w11", 0, 1, 0, 'h011, 32'hAAAA0002, 0, 0, 0);
        cyc("r10", 0, 0, 1, 'h010, 0, 32'h12345678, 0, 0);
        for (int i = 0; i < 3; i++) rd_entry($sformatf("basic.idx%0d", i), i);
        chk("basic.count3", 64'(tr_count), 3);
        rd_entry("basic.idx5", 5);
        // readout concurrent with a capture sees pre-capture contents
        cyc("rd_with_cap", 0, 1, 0, 'h012, 32'hAAAA0003, 0, 1, 3);

        // conflict access
        cyc("conf", 0, 1, 1, 'h020, 32'hDEADBEEF, 32'h0BAD0BAD, 0, 0);
        rd_entry("conf.entry", 4);
        chk("conf.kind", 64'(tr_rdata[EW-1:EW-2]), 3);

        // trigger window
        trig_addr = 10'h3FF; trig_en = 1;
        cyc("arm2", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("pre0", 0, 1, 0, 'h100, 32'h100, 0, 0, 0);
        cyc("pre1", 0, 0, 1, 'h101, 0, 32'h101, 0, 0);
        cyc("trig", 0, 1, 0, 'h3FF, 32'h3FF, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc($sformatf("post%0d", i), 0, i % 2, ~i % 2, 'h3FF - i, 32'(i), 32'(i + 7), 0, 0);
        chk("trig.frozen", 64'(state_o), 3);
        chk("trig.count7", 64'(tr_count), 7);
        chk("trig.total", 64'(rd_cnt + wr_cnt + conf_cnt), 9);
        rd_entry("trig.idx2", 2);
        chk("trig.idx2addr", 64'(tr_rdata[DW +: AW]), 'h3FF);

        // wraparound without trigger
        trig_en = 0;
        cyc("arm3", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc($sformatf("wrap%0d", i), 0, 1, 0, i, 32'(i * 3), 0, 0, 0);
        chk("wrap.count16", 64'(tr_count), 16);
        rd_entry("wrap.idx0", 0);
        chk("wrap.idx0addr", 64'(tr_rdata[DW +: AW]), 4);
        rd_entry("wrap.idx15", 15);
        chk("wrap.idx15addr", 64'(tr_rdata[DW +: AW]), 19);

        // arm wins over a concurrent write and readout
        cyc("arm_wr", 1, 1, 0, 'h055, 32'h5555, 0, 1, 0);
        rd_entry("arm_wr.idx0", 0);
        chk("arm_wr.wr_cnt", 64'(wr_cnt), 0);

        // async reset mid-POST
        trig_addr = 10'h040; trig_en = 1;
        cyc("arm4", 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4", 0, 1, 0, 'h040, 32'h40, 0, 0, 0);
        cyc("t4p", 0, 1, 0, 'h041, 32'h41, 0, 0, 0);
        #2 rst_l = 0; #1;
        model_reset();
        check_regs("midrst");
        chk("midrst.valid", 64'(tr_valid), 0);
        #1 rst_l = 1;
        for (int i = 0; i < 3; i++) cyc($sformatf("postrst%0d", i), 0, 1, i == 1, 'h040, 32'(i), 32'(i), 1, 0);

        // randomized traffic
        trig_addr = 10'h155;
        cyc("arm_rand", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            int addr;
            trig_en = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 5) == 0) ? 'h155 : int'($urandom_range(0, 1023));
            cyc($sformatf("rnd%0d", n), $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, addr, $urandom, $urandom,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
